// File: rtl/cmd_processor_mc_if.sv
`default_nettype none
// ============================================================================
//  Module   : cmd_processor_mc_if
//  Purpose  : Bundles the two AXI-stream links of the command processor.
//             The i_* signals are the 8-bit command stream from the host
//             bridge. The o_* signals are the 32-bit response/sample stream
//             back to the host.
//  Modports : slave  - command processor side (consumes i_*, produces o_*)
//             master - host/bridge side (produces i_*, consumes o_*)
//  Revision : 1.0 - initial release
// ============================================================================
interface cmd_processor_mc_if;
    logic        i_tready;
    logic        i_tvalid;
    logic [7:0]  i_tdata;
    logic        o_tready;
    logic        o_tvalid;
    logic [31:0] o_tdata;
    logic [3:0]  o_tkeep;
    logic        o_tlast;

    modport slave (
        output i_tready,
        input  i_tvalid, i_tdata,
        input  o_tready,
        output o_tvalid, o_tdata, o_tkeep, o_tlast
    );

    modport master (
        input  i_tready,
        output i_tvalid, i_tdata,
        output o_tready,
        input  o_tvalid, o_tdata, o_tkeep, o_tlast
    );
endinterface
`default_nettype wire

// File: rtl/cmd_processor_mc.sv
`default_nettype none
// ============================================================================
//  Module   : cmd_processor_mc
//  Purpose  : Host command processor. It collects fixed-length byte commands
//             and runs one of four actions:
//               clock-switch toggle, version read, SPI transaction,
//               ADC channel streaming.
//             Responses go out on a 32-bit AXI-stream.
//  Ports    : clk, rstn          - clock, async active-low reset
//             bus (slave)        - command in / response out streams
//             clkswitch          - PLL input clock select
//             spitx/spitxdv      - byte + strobe to the SPI master
//             spitxready         - SPI master idle
//             spirx/spirxdv      - received byte + strobe from the SPI master
//             spics              - active-low chip selects
//             lvdsbits           - deserialised ADC bus, SAMPLE_W bits/channel
//  Revision : 1.0 - initial release
// ============================================================================
module cmd_processor_mc #(
    parameter int CMD_BYTES   = 8,
    parameter int NUM_CS      = 4,
    parameter int LVDS_W      = 140,
    parameter int SAMPLE_W    = 10,
    parameter int VERSION     = 5,
    parameter int SPI_TIMEOUT = 4096,
    parameter int RX_TIMEOUT  = 65535
) (
    input  logic                 clk,
    input  logic                 rstn,
    cmd_processor_mc_if.slave    bus,
    output logic                 clkswitch,
    output logic [7:0]           spitx,
    output logic                 spitxdv,
    input  logic                 spitxready,
    input  logic [7:0]           spirx,
    input  logic                 spirxdv,
    output logic [NUM_CS-1:0]    spics,
    input  logic [LVDS_W-1:0]    lvdsbits
);

    localparam int NCH = LVDS_W / SAMPLE_W;
    localparam int CW  = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
    localparam int IW  = $clog2(RX_TIMEOUT + 1);
    localparam int TW  = $clog2(SPI_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RX     = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_SPI    = 3'd3;
    localparam logic [2:0] S_TX     = 3'd4;

    // SPI sub-phase: waiting for the master to be idle, or for the reply byte.
    localparam logic P_WTX = 1'b0;
    localparam logic P_WRX = 1'b1;

    localparam logic [31:0] ERR_WORD = 32'hEEEE_EEEE;

    logic [2:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [7:0]          cmd_q [CMD_BYTES];
    logic [7:0]          cmd_d [CMD_BYTES];
    logic [IW-1:0]       idle_q, idle_d;
    logic                clk_q, clk_d;
    logic [31:0]         rem_q, rem_d;
    logic                stream_q, stream_d;
    logic [31:0]         word_q, word_d;
    logic                phase_q, phase_d;
    logic [1:0]          sidx_q, sidx_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [NUM_CS-1:0]   spics_q, spics_d;
    logic [7:0]          spitx_q, spitx_d;
    logic                spitxdv_q, spitxdv_d;

    logic                w_i_tready;
    logic                w_o_tvalid;
    logic [3:0]          w_o_tkeep;
    logic                w_o_tlast;

    // Out-of-range channels read as zero.
    function automatic logic [15:0] sample(input logic [7:0] ch,
                                           input logic [LVDS_W-1:0] bits);
        logic [15:0] s;
        s = 16'h0000;
        for (int c = 0; c < NCH; c++) begin
            if (ch == 8'(c)) s = 16'(bits[c*SAMPLE_W +: SAMPLE_W]);
        end
        return s;
    endfunction

    logic [31:0] w_len;
    logic [31:0] w_sword;
    logic [1:0]  w_nlast;
    logic [7:0]  w_nxt_byte;

    always_comb begin
        w_len   = {cmd_q[7], cmd_q[6], cmd_q[5], cmd_q[4]};
        w_sword = {sample(cmd_q[2], lvdsbits), sample(cmd_q[1], lvdsbits)};
        // Byte count 0 or >3 means 3; index of the final byte is count-1.
        w_nlast = (cmd_q[5] == 8'd0 || cmd_q[5] > 8'd3) ? 2'd2 : (cmd_q[5][1:0] - 2'd1);
        case (sidx_q)
            2'd0:    w_nxt_byte = cmd_q[3];
            default: w_nxt_byte = cmd_q[4];
        endcase
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            for (int i = 0; i < CMD_BYTES; i++) cmd_q[i] <= 8'h00;
            idle_q    <= '0;
            clk_q     <= 1'b0;
            rem_q     <= 32'd0;
            stream_q  <= 1'b0;
            word_q    <= 32'd0;
            phase_q   <= P_WTX;
            sidx_q    <= 2'd0;
            timer_q   <= '0;
            spics_q   <= '1;
            spitx_q   <= 8'h00;
            spitxdv_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            idle_q    <= idle_d;
            clk_q     <= clk_d;
            rem_q     <= rem_d;
            stream_q  <= stream_d;
            word_q    <= word_d;
            phase_q   <= phase_d;
            sidx_q    <= sidx_d;
            timer_q   <= timer_d;
            spics_q   <= spics_d;
            spitx_q   <= spitx_d;
            spitxdv_q <= spitxdv_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        idle_d    = idle_q;
        clk_d     = clk_q;
        rem_d     = rem_q;
        stream_d  = stream_q;
        word_d    = word_q;
        phase_d   = phase_q;
        sidx_d    = sidx_q;
        timer_d   = timer_q;
        spics_d   = spics_q;
        spitx_d   = spitx_q;
        spitxdv_d = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_RX;

            S_RX: begin
                if (bus.i_tvalid) begin
                    cmd_d[cnt_q] = bus.i_tdata;
                    idle_d       = '0;
                    if (cnt_q == CW'(CMD_BYTES - 1)) begin
                        cnt_d   = '0;
                        state_d = S_DECODE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (cnt_q != '0) begin
                    // A stalled partial command is silently dropped.
                    if (idle_q == IW'(RX_TIMEOUT - 1)) begin
                        cnt_d  = '0;
                        idle_d = '0;
                    end else begin
                        idle_d = idle_q + IW'(1);
                    end
                end
            end

            S_DECODE: begin
                state_d = S_RX;
                case (cmd_q[0])
                    8'd0: begin
                        if (w_len != 32'd0) begin
                            rem_d    = w_len;
                            stream_d = 1'b1;
                            word_d   = w_sword;
                            state_d  = S_TX;
                        end
                    end
                    8'd1: begin
                        clk_d    = ~clk_q;
                        word_d   = {31'd0, ~clk_q};
                        rem_d    = 32'd4;
                        stream_d = 1'b0;
                        state_d  = S_TX;
                    end
                    8'd2: begin
                        word_d   = 32'(VERSION);
                        rem_d    = 32'd4;
                        stream_d = 1'b0;
                        state_d  = S_TX;
                    end
                    8'd3: begin
                        stream_d = 1'b0;
                        rem_d    = 32'd4;
                        if (cmd_q[1] >= 8'(NUM_CS)) begin
                            word_d  = ERR_WORD;
                            state_d = S_TX;
                        end else begin
                            for (int k = 0; k < NUM_CS; k++) begin
                                if (cmd_q[1] == 8'(k)) spics_d[k] = 1'b0;
                            end
                            spitx_d = cmd_q[2];
                            sidx_d  = 2'd0;
                            phase_d = P_WTX;
                            timer_d = '0;
                            state_d = S_SPI;
                        end
                    end
                    default: ;
                endcase
            end

            S_SPI: begin
                if (phase_q == P_WTX && spitxready) begin
                    spitxdv_d = 1'b1;
                    phase_d   = P_WRX;
                    timer_d   = '0;
                end else if (phase_q == P_WRX && spirxdv) begin
                    timer_d = '0;
                    if (sidx_q == w_nlast) begin
                        spics_d = '1;
                        word_d  = {24'd0, spirx};
                        state_d = S_TX;
                    end else begin
                        sidx_d  = sidx_q + 2'd1;
                        spitx_d = w_nxt_byte;
                        phase_d = P_WTX;
                    end
                end else if (timer_q == TW'(SPI_TIMEOUT - 1)) begin
                    spics_d = '1;
                    word_d  = ERR_WORD;
                    state_d = S_TX;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            S_TX: begin
                if (bus.o_tready) begin
                    if (rem_q <= 32'd4) begin
                        rem_d   = 32'd0;
                        state_d = S_RX;
                    end else begin
                        rem_d = rem_q - 32'd4;
                        if (stream_q) word_d = w_sword;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        w_i_tready = (state_q == S_RX);
        w_o_tvalid = (state_q == S_TX);
        w_o_tlast  = (rem_q <= 32'd4);
        if (rem_q >= 32'd4)      w_o_tkeep = 4'b1111;
        else if (rem_q == 32'd3) w_o_tkeep = 4'b0111;
        else if (rem_q == 32'd2) w_o_tkeep = 4'b0011;
        else if (rem_q == 32'd1) w_o_tkeep = 4'b0001;
        else                     w_o_tkeep = 4'b0000;
    end

    assign bus.i_tready = w_i_tready;
    assign bus.o_tvalid = w_o_tvalid;
    assign bus.o_tdata  = word_q;
    assign bus.o_tkeep  = w_o_tkeep;
    assign bus.o_tlast  = w_o_tlast;
    assign clkswitch    = clk_q;
    assign spitx        = spitx_q;
    assign spitxdv      = spitxdv_q;
    assign spics        = spics_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_processor_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cmd_processor_mc
//  Purpose  : Directed self-checking bench for cmd_processor_mc. It includes
//             a small SPI master model and an AXI-stream host.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_processor_mc;

    localparam int SPI_TO = 32;
    localparam int RX_TO  = 64;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         clkswitch;
    logic [7:0]   spitx;
    logic         spitxdv;
    logic         spitxready;
    logic [7:0]   spirx;
    logic         spirxdv;
    logic [3:0]   spics;
    logic [139:0] lvdsbits;
    logic         spi_block;

    always #5 clk = ~clk;

    cmd_processor_mc_if bus ();

    cmd_processor_mc #(
        .CMD_BYTES(8), .NUM_CS(4), .LVDS_W(140), .SAMPLE_W(10), .VERSION(5),
        .SPI_TIMEOUT(SPI_TO), .RX_TIMEOUT(RX_TO)
    ) dut (
        .clk(clk), .rstn(rstn), .bus(bus),
        .clkswitch(clkswitch), .spitx(spitx), .spitxdv(spitxdv),
        .spitxready(spitxready), .spirx(spirx), .spirxdv(spirxdv),
        .spics(spics), .lvdsbits(lvdsbits)
    );

    // SPI master model: goes busy on spitxdv, answers 0x3C three cycles later.
    logic m_ready, m_rxdv;
    int   m_dly;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_ready <= 1'b1; m_rxdv <= 1'b0; m_dly <= 0;
        end else begin
            m_rxdv <= 1'b0;
            if (spitxdv && !spi_block) begin
                m_ready <= 1'b0; m_dly <= 3;
            end else if (m_dly > 0) begin
                m_dly <= m_dly - 1;
                if (m_dly == 1) begin m_rxdv <= 1'b1; m_ready <= 1'b1; end
            end
        end
    end
    assign spitxready = m_ready & ~spi_block;
    assign spirxdv    = m_rxdv;
    assign spirx      = m_rxdv ? 8'h3C : 8'h00;

    // spitxdv pulse monitor
    int         pulses;
    logic [7:0] txlog [4];
    logic [3:0] cs_at_pulse;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) pulses <= 0;
        else if (spitxdv) begin
            txlog[pulses & 3] <= spitx;
            cs_at_pulse       <= spics;
            pulses            <= pulses + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bytes are sent MSB-first: c[63:56] is byte 0.
    task automatic send_bytes(input logic [63:0] c, input int nb);
        for (int i = 0; i < nb; i++) begin
            int t;
            @(negedge clk);
            bus.i_tvalid = 1'b1;
            bus.i_tdata  = c[63-8*i -: 8];
            #1;
            t = 0;
            while (!bus.i_tready && t < 50) begin
                @(negedge clk); #1; t++;
            end
            if (t >= 50) check("rx_ready_wait", {31'd0, bus.i_tready}, 32'd1);
            @(posedge clk);
        end
        @(negedge clk);
        bus.i_tvalid = 1'b0;
    endtask

    logic [31:0] bd [8];
    logic [3:0]  bk [8];
    logic        bl [8];
    int          nbeats;

    task automatic get_beats(input bit toggle, input int budget);
        bit          stalled = 0;
        bit          done = 0;
        logic [31:0] sd = 32'd0;
        nbeats = 0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            bus.o_tready = toggle ? ~bus.o_tready : 1'b1;
            #1;
            if (bus.o_tvalid) begin
                if (stalled) check("tx_hold", bus.o_tdata, sd);
                if (bus.o_tready) begin
                    stalled = 0;
                    if (nbeats < 8) begin
                        bd[nbeats] = bus.o_tdata;
                        bk[nbeats] = bus.o_tkeep;
                        bl[nbeats] = bus.o_tlast;
                    end
                    nbeats++;
                    if (bus.o_tlast) done = 1;
                end else begin
                    stalled = 1;
                    sd = bus.o_tdata;
                end
            end
        end
        check("tx_done", {31'd0, done}, 32'd1);
        bus.o_tready = 1'b1;
    endtask

    task automatic expect_none(input string tag, input int n);
        int v = 0;
        repeat (n) begin
            @(negedge clk); #1;
            if (bus.o_tvalid) v++;
        end
        check(tag, v, 0);
    endtask

    task automatic check_stream();
        logic [3:0] ek [3];
        ek[0] = 4'b1111; ek[1] = 4'b1111; ek[2] = 4'b0011;
        check("stream_beats", nbeats, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stream_data%0d", i), bd[i], 32'h02AA_0155);
            check($sformatf("stream_keep%0d", i), {28'd0, bk[i]}, {28'd0, ek[i]});
            check($sformatf("stream_last%0d", i), {31'd0, bl[i]}, (i == 2) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t;
        bus.i_tvalid = 1'b0;
        bus.i_tdata  = 8'h00;
        bus.o_tready = 1'b1;
        spi_block    = 1'b0;
        lvdsbits     = '0;
        lvdsbits[1*10 +: 10] = 10'h155;
        lvdsbits[3*10 +: 10] = 10'h2AA;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_tvalid",  {31'd0, bus.o_tvalid}, 32'd0);
        check("rst_tready",  {31'd0, bus.i_tready}, 32'd0);
        check("rst_tdata",   bus.o_tdata, 32'd0);
        check("rst_clksw",   {31'd0, clkswitch}, 32'd0);
        check("rst_spics",   {28'd0, spics}, 32'hF);
        check("rst_spitxdv", {31'd0, spitxdv}, 32'd0);
        check("rst_spitx",   {24'd0, spitx}, 32'd0);
        @(negedge clk); rstn = 1'b1;
        repeat (2) @(negedge clk);
        #1 check("rx_ready", {31'd0, bus.i_tready}, 32'd1);

        // Version read
        send_bytes(64'h0200_0000_0000_0000, 8);
        get_beats(0, 100);
        check("ver_beats", nbeats, 1);
        check("ver_data", bd[0], 32'd5);
        check("ver_keep", {28'd0, bk[0]}, 32'hF);
        check("ver_last", {31'd0, bl[0]}, 32'd1);
        @(negedge clk); #1 check("ver_ready_back", {31'd0, bus.i_tready}, 32'd1);

        // Streaming, L=10, then with back-pressure
        send_bytes(64'h0001_0300_0A00_0000, 8);
        get_beats(0, 100);
        check_stream();
        send_bytes(64'h0001_0300_0A00_0000, 8);
        bus.o_tready = 1'b0;
        get_beats(1, 200);
        check_stream();

        // SPI on cs=2, two bytes
        base = pulses;
        send_bytes(64'h0302_8005_0002_0000, 8);
        get_beats(0, 200);
        check("spi_beats", nbeats, 1);
        check("spi_data", bd[0], 32'h0000_003C);
        check("spi_pulses", pulses - base, 2);
        check("spi_byte0", {24'd0, txlog[base & 3]}, 32'h80);
        check("spi_byte1", {24'd0, txlog[(base + 1) & 3]}, 32'h05);
        check("spi_cs_active", {28'd0, cs_at_pulse}, 32'b1011);
        @(negedge clk); #1 check("spi_cs_release", {28'd0, spics}, 32'hF);

        // SPI timeout with spitxready held low
        spi_block = 1'b1;
        base = pulses;
        send_bytes(64'h0301_AA00_0001_0000, 8);
        @(negedge clk); #1 check("to_cs_active", {28'd0, spics}, 32'b1101);
        get_beats(0, 200);
        check("to_data", bd[0], 32'hEEEE_EEEE);
        check("to_pulses", pulses - base, 0);
        check("to_cs_release", {28'd0, spics}, 32'hF);
        spi_block = 1'b0;

        // Chip select out of range
        base = pulses;
        send_bytes(64'h0305_1100_0001_0000, 8);
        get_beats(0, 100);
        check("badcs_data", bd[0], 32'hEEEE_EEEE);
        check("badcs_pulses", pulses - base, 0);

        // Partial command dropped after RX timeout, then clock-switch toggle
        send_bytes(64'h0200_0000_0000_0000, 3);
        repeat (RX_TO) @(posedge clk);
        send_bytes(64'h0100_0000_0000_0000, 8);
        get_beats(0, 100);
        check("clksw_beats", nbeats, 1);
        check("clksw_data", bd[0], 32'd1);
        @(negedge clk); #1 check("clksw_out", {31'd0, clkswitch}, 32'd1);
        expect_none("clksw_no_extra", 10);

        // Unknown opcode and zero-length stream produce nothing
        send_bytes(64'h0700_0000_0000_0000, 8);
        expect_none("op7_none", 20);
        send_bytes(64'h0001_0300_0000_0000, 8);
        expect_none("len0_none", 20);

        // Reset during the second TX beat
        send_bytes(64'h0001_0300_0A00_0000, 8);
        t = 0;
        #1;
        while (!bus.o_tvalid && t < 50) begin @(negedge clk); #1; t++; end
        check("rst_tx_reach", {31'd0, bus.o_tvalid}, 32'd1);
        @(negedge clk); bus.o_tready = 1'b0; #1;
        check("rst_tx_beat2_keep", {28'd0, bus.o_tkeep}, 32'hF);
        rstn = 1'b0; #1;
        check("rst_tx_tvalid", {31'd0, bus.o_tvalid}, 32'd0);
        check("rst_tx_tdata", bus.o_tdata, 32'd0);
        check("rst_tx_clksw", {31'd0, clkswitch}, 32'd0);
        @(negedge clk); rstn = 1'b1; bus.o_tready = 1'b1;
        repeat (2) @(negedge clk);
        send_bytes(64'h0200_0000_0000_0000, 8);
        get_beats(0, 100);
        check("post_rst_ver", bd[0], 32'd5);

        // Reset during SPI wait releases the chip select at once
        spi_block = 1'b1;
        send_bytes(64'h0300_1100_0001_0000, 8);
        repeat (2) @(negedge clk);
        #1 check("rst_spi_active", {28'd0, spics}, 32'b1110);
        rstn = 1'b0; #1;
        check("rst_spi_cs", {28'd0, spics}, 32'hF);
        @(negedge clk); rstn = 1'b1; spi_block = 1'b0;
        repeat (2) @(negedge clk);
        send_bytes(64'h0200_0000_0000_0000, 8);
        get_beats(0, 100);
        check("post_rst2_ver", bd[0], 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
